bcd_entry: RTL and testbench

BCD_ENTRY -- requirements
Module: bcd_entry

---
 rtl/bcd_entry.sv | 152 +++++++++++++++
 tb/tb_bcd_entry.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry.sv
// ============================================================================
//  Module      : bcd_entry
//  Description : Two-digit BCD keypad entry with a synchronized pushbutton and
//                range check; the result is held until the consumer acknowledges it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_entry #(
    parameter int MAX_VALUE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       clear,
    input  logic       ack,
    output logic [3:0] value,
    output logic       valid,
    output logic [3:0] tens_dgt,
    output logic [3:0] ones_dgt,
    output logic       error,
    output logic [1:0] state
);

    localparam logic [3:0] c_MAX_TENS = 4'(MAX_VALUE / 10);
    localparam logic [4:0] c_MAX_SUM  = 5'(MAX_VALUE);

    typedef enum logic [1:0] {
        GET_TENS = 2'd0,
        GET_ONES = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] value_q, value_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;
    logic       started_q, started_d;
    logic       armed_q, armed_d;

    logic       w_enter_ev;
    logic [4:0] w_sum;

    // armed only after the synchronized button has been seen low since reset,
    // so a button held through reset cannot fire an event on release.
    assign w_enter_ev = sync2_q & ~sync3_q & armed_q;
    assign w_sum      = 5'(tens_q) * 5'd10 + 5'(digit_in);

    always_comb begin
        sync1_d   = enter;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        started_d = 1'b1;
        armed_d   = armed_q | (started_q & ~sync1_q);

        state_d = state_q;
        value_d = value_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        error_d = error_q;

        if (clear) begin
            state_d = GET_TENS;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            error_d = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                GET_TENS: begin
                    if (w_enter_ev) begin
                        if (digit_in <= c_MAX_TENS) begin
                            tens_d  = digit_in;
                            ones_d  = 4'd0;
                            error_d = 1'b0;
                            state_d = GET_ONES;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                GET_ONES: begin
                    if (w_enter_ev) begin
                        if ((digit_in <= 4'd9) && (w_sum <= c_MAX_SUM)) begin
                            ones_d  = digit_in;
                            value_d = w_sum[3:0];
                            valid_d = 1'b1;
                            error_d = 1'b0;
                            state_d = HOLD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid_d = 1'b0;
                        state_d = GET_TENS;
                    end
                end
                default: begin
                    state_d = GET_TENS;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET_TENS;
            value_q   <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            started_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            started_q <= started_d;
            armed_q   <= armed_d;
        end
    end

    assign value    = value_q;
    assign valid    = valid_q;
    assign tens_dgt = tens_q;
    assign ones_dgt = ones_q;
    assign error    = error_q;
    assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_entry.sv
// ============================================================================
//  Module      : tb_bcd_entry
//  Description : Directed self-checking bench for bcd_entry (MAX_VALUE = 15).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_entry;

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       enter;
    logic       clear;
    logic       ack;
    logic [3:0] value;
    logic       valid;
    logic [3:0] tens_dgt;
    logic [3:0] ones_dgt;
    logic       error;
    logic [1:0] state;

    int n_tests;
    int n_fail;

    bcd_entry #(.MAX_VALUE(15)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .digit_in (digit_in),
        .enter    (enter),
        .clear    (clear),
        .ack      (ack),
        .value    (value),
        .valid    (valid),
        .tens_dgt (tens_dgt),
        .ones_dgt (ones_dgt),
        .error    (error),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit_in = d;
        enter    = 1'b1;
        cycles(4);
        enter = 1'b0;
        cycles(4);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"}, 8'(value), 8'd0);
        check({tag, "_valid"}, 8'(valid), 8'd0);
        check({tag, "_tens"},  8'(tens_dgt), 8'd0);
        check({tag, "_ones"},  8'(ones_dgt), 8'd0);
        check({tag, "_error"}, 8'(error), 8'd0);
        check({tag, "_state"}, 8'(state), 8'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        digit_in = 4'd0;
        enter    = 1'b0;
        clear    = 1'b0;
        ack      = 1'b0;
        cycles(3);
        check_all_zero("reset");
        rst = 1'b0;
        cycles(3);

        // Basic entry 1,2 then ack
        press(4'd1);
        check("e12_state1", 8'(state), 8'd1);
        check("e12_tens1", 8'(tens_dgt), 8'd1);
        check("e12_ones0", 8'(ones_dgt), 8'd0);
        press(4'd2);
        check("e12_valid", 8'(valid), 8'd1);
        check("e12_value", 8'(value), 8'd12);
        check("e12_tens", 8'(tens_dgt), 8'd1);
        check("e12_ones", 8'(ones_dgt), 8'd2);
        check("e12_state", 8'(state), 8'd2);
        pulse_ack();
        check("ack_valid", 8'(valid), 8'd0);
        check("ack_state", 8'(state), 8'd0);
        check("ack_value", 8'(value), 8'd12);
        check("ack_tens_kept", 8'(tens_dgt), 8'd1);

        // Tens out of range, then 0,7
        press(4'd2);
        check("t2_error", 8'(error), 8'd1);
        check("t2_state", 8'(state), 8'd0);
        check("t2_tens_kept", 8'(tens_dgt), 8'd1);
        check("t2_ones_kept", 8'(ones_dgt), 8'd2);
        press(4'd0);
        check("t0_error_clr", 8'(error), 8'd0);
        press(4'd7);
        check("e07_value", 8'(value), 8'd7);
        check("e07_valid", 8'(valid), 8'd1);
        check("e07_error", 8'(error), 8'd0);
        pulse_ack();

        // Sum above limit, then at the limit
        press(4'd1);
        press(4'd6);
        check("s16_error", 8'(error), 8'd1);
        check("s16_state", 8'(state), 8'd1);
        check("s16_tens", 8'(tens_dgt), 8'd1);
        check("s16_valid", 8'(valid), 8'd0);
        press(4'd12);
        check("s22_error", 8'(error), 8'd1);
        check("s22_state", 8'(state), 8'd1);
        press(4'd5);
        check("s15_value", 8'(value), 8'd15);
        check("s15_valid", 8'(valid), 8'd1);
        check("s15_error", 8'(error), 8'd0);
        pulse_ack();

        // Ones digit above 9 rejected even with sum in range
        press(4'd0);
        press(4'd10);
        check("o10_error", 8'(error), 8'd1);
        check("o10_state", 8'(state), 8'd1);
        check("o10_value_kept", 8'(value), 8'd15);
        pulse_clear();
        check("clr_state", 8'(state), 8'd0);
        check("clr_error", 8'(error), 8'd0);
        check("clr_value_kept", 8'(value), 8'd15);

        // ack outside HOLD ignored
        press(4'd0);
        pulse_ack();
        check("ack_getones_state", 8'(state), 8'd1);

        // HOLD ignores enter presses
        press(4'd9);
        check("h9_state", 8'(state), 8'd2);
        press(4'd3);
        press(4'd1);
        press(4'd0);
        check("h9_valid", 8'(valid), 8'd1);
        check("h9_value", 8'(value), 8'd9);
        check("h9_error", 8'(error), 8'd0);
        check("h9_state_kept", 8'(state), 8'd2);

        // clear and ack together in HOLD
        @(negedge clk);
        clear = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ack   = 1'b0;
        check("clrack_state", 8'(state), 8'd0);
        check("clrack_valid", 8'(valid), 8'd0);
        check("clrack_ones", 8'(ones_dgt), 8'd0);
        check("clrack_value", 8'(value), 8'd9);

        // Held enter: one event on the 3rd edge, none afterwards
        @(negedge clk);
        digit_in = 4'd0;
        enter    = 1'b1;
        cycles(2);
        check("held_edge2_state", 8'(state), 8'd0);
        cycles(1);
        check("held_edge3_state", 8'(state), 8'd1);
        digit_in = 4'd1;
        cycles(17);
        check("held_no_second_ev", 8'(state), 8'd1);
        check("held_valid", 8'(valid), 8'd0);
        enter = 1'b0;
        cycles(4);
        pulse_clear();

        // ack and enter_ev in the same cycle in HOLD lose the event
        press(4'd1);
        press(4'd3);
        check("ae_hold", 8'(state), 8'd2);
        @(negedge clk);
        digit_in = 4'd0;
        enter    = 1'b1;
        cycles(2);
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        check("ae_state", 8'(state), 8'd0);
        cycles(5);
        check("ae_ev_lost", 8'(state), 8'd0);
        enter = 1'b0;
        cycles(4);

        // rst mid-entry in GET_ONES
        press(4'd1);
        check("rst_pre_state", 8'(state), 8'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        cycles(3);

        // enter high across reset release yields no event until re-pressed
        @(negedge clk);
        rst      = 1'b1;
        enter    = 1'b1;
        digit_in = 4'd0;
        cycles(2);
        rst = 1'b0;
        cycles(10);
        check("rst_held_no_ev", 8'(state), 8'd0);
        enter = 1'b0;
        cycles(4);
        press(4'd0);
        check("rst_held_repress", 8'(state), 8'd1);

        do_reset();
        check_all_zero("final_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
